// File: rtl/processor_pkg.sv
// Shared definitions for the 16-bit, 8-register datapath: widths, the r0
// constant, the decoded instruction field bundle and small helpers used by
// decode, operand fetch and execute.
package processor_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int AW     = 3;

  localparam logic [AW-1:0] R0 = 3'd0;

  // Register fields of a decoded instruction.
  typedef struct packed {
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [AW-1:0] rc;
    logic          use_ra;
    logic          wr_ra;
  } instr_fields_t;

  // Operand holding register occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } hold_state_t;

  // Second source register: rA for store/branch forms, rC otherwise.
  function automatic logic [AW-1:0] src2_addr(input instr_fields_t f);
    return f.use_ra ? f.ra : f.rc;
  endfunction

  // One-hot decode of a register address.
  function automatic logic [NREG-1:0] reg_onehot(input logic [AW-1:0] a);
    logic [NREG-1:0] v;
    v    = {NREG{1'b0}};
    v[a] = 1'b1;
    return v;
  endfunction

  // True when the writeback in flight this cycle targets register q (never r0).
  function automatic logic wb_targets(input logic wb_v, input logic [AW-1:0] wb_a,
                                      input logic [AW-1:0] q);
    return wb_v && (wb_a == q) && (q != R0);
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Bundle of the operand-fetch stage's handshake and bus signals: decoded
// instruction in, register-file read port, writeback snoop, and operands out.
// The slave modport is the stage's own view; master is the surrounding pipeline.
interface operand_fetch_if;
  import processor_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [AW-1:0]     in_ra;
  logic [AW-1:0]     in_rb;
  logic [AW-1:0]     in_rc;
  logic              in_use_ra;
  logic              in_wr_ra;

  logic [AW-1:0]     rf_addr1;
  logic [AW-1:0]     rf_addr2;
  logic              rf_mux;
  logic [DATA_W-1:0] rf_data1;
  logic [DATA_W-1:0] rf_data2;

  logic              wb_valid;
  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_op1;
  logic [DATA_W-1:0] out_op2;
  logic [AW-1:0]     out_dest;
  logic              out_wr;

  modport slave (
    input  in_valid, in_ra, in_rb, in_rc, in_use_ra, in_wr_ra,
    output in_ready,
    output rf_addr1, rf_addr2, rf_mux,
    input  rf_data1, rf_data2,
    input  wb_valid, wb_addr, wb_data,
    output out_valid, out_op1, out_op2, out_dest, out_wr,
    input  out_ready
  );

  modport master (
    output in_valid, in_ra, in_rb, in_rc, in_use_ra, in_wr_ra,
    input  in_ready,
    input  rf_addr1, rf_addr2, rf_mux,
    output rf_data1, rf_data2,
    output wb_valid, wb_addr, wb_data,
    input  out_valid, out_op1, out_op2, out_dest, out_wr,
    output out_ready
  );

endinterface

// File: rtl/pending_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when a
// writer issues and cleared when its writeback commits. When a set and a clear
// hit the same register in one cycle the set wins, since the clear belongs to
// an older write. r0 is never marked pending. Three query ports report hits.
module pending_scoreboard
  import processor_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] q1_addr,
  input  logic [AW-1:0] q2_addr,
  input  logic [AW-1:0] q3_addr,
  output logic          hit1,
  output logic          hit2,
  output logic          hit3
);

  logic [NREG-1:0] r_sb;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;
  logic [NREG-1:0] w_sb_next;

  assign w_set_mask = (set_en && (set_addr != R0)) ? reg_onehot(set_addr) : {NREG{1'b0}};
  assign w_clr_mask = (clr_en && (clr_addr != R0)) ? reg_onehot(clr_addr) : {NREG{1'b0}};
  // Clear first, then OR in the set so a same-register collision stays pending.
  assign w_sb_next  = (r_sb & ~w_clr_mask) | w_set_mask;

  assign hit1 = r_sb[q1_addr] && (q1_addr != R0);
  assign hit2 = r_sb[q2_addr] && (q2_addr != R0);
  assign hit3 = r_sb[q3_addr] && (q3_addr != R0);

  // Pending vector update; reset drops every outstanding write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sb <= {NREG{1'b0}};
    end else begin
      r_sb <= w_sb_next;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Register-read issue stage. Drives the register file read addresses straight
// from the decoded fields, stalls on pending writes tracked by the scoreboard,
// and captures operands into a single holding register offered to execute
// over valid/ready.
// Optional feature macro: OPERAND_FETCH_WB_BYPASS_EN -- when defined, a source
// whose pending write commits this same cycle is not a hazard and its operand
// is taken from wb_data, saving one stall cycle.
module operand_fetch
  import processor_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  operand_fetch_if.slave bus
);

  instr_fields_t     w_instr;
  logic [AW-1:0]     w_src2;
  logic              w_hit_b;
  logic              w_hit_s2;
  logic              w_hit_a;
  logic              w_byp_b;
  logic              w_byp_s2;
  logic              w_byp_a;
  logic              w_hazard;
  logic              w_in_ready;
  logic              w_accept;
  logic [DATA_W-1:0] w_op1;
  logic [DATA_W-1:0] w_op2;

  hold_state_t       r_state;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_op1;
  logic [DATA_W-1:0] r_op2;
  logic [AW-1:0]     r_dest;
  logic              r_wr;

  assign w_instr.ra     = bus.in_ra;
  assign w_instr.rb     = bus.in_rb;
  assign w_instr.rc     = bus.in_rc;
  assign w_instr.use_ra = bus.in_use_ra;
  assign w_instr.wr_ra  = bus.in_wr_ra;
  assign w_src2         = src2_addr(w_instr);

  // Read port addressing does not depend on in_valid.
  assign bus.rf_addr1 = w_instr.rb;
  assign bus.rf_addr2 = w_src2;
  assign bus.rf_mux   = w_instr.use_ra;

`ifdef OPERAND_FETCH_WB_BYPASS_EN
  assign w_byp_b  = wb_targets(bus.wb_valid, bus.wb_addr, w_instr.rb);
  assign w_byp_s2 = wb_targets(bus.wb_valid, bus.wb_addr, w_src2);
  assign w_byp_a  = wb_targets(bus.wb_valid, bus.wb_addr, w_instr.ra);
`else
  // The register file only holds the new value after the edge, so a
  // same-cycle writeback still stalls the reader.
  assign w_byp_b  = 1'b0;
  assign w_byp_s2 = 1'b0;
  assign w_byp_a  = 1'b0;
`endif

  pending_scoreboard u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (w_accept && w_instr.wr_ra),
    .set_addr (w_instr.ra),
    .clr_en   (bus.wb_valid),
    .clr_addr (bus.wb_addr),
    .q1_addr  (w_instr.rb),
    .q2_addr  (w_src2),
    .q3_addr  (w_instr.ra),
    .hit1     (w_hit_b),
    .hit2     (w_hit_s2),
    .hit3     (w_hit_a)
  );

  assign w_hazard   = (w_hit_b && !w_byp_b) ||
                      (w_hit_s2 && !w_byp_s2) ||
                      (w_instr.wr_ra && w_hit_a && !w_byp_a);
  assign w_in_ready = !w_hazard && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  // r0 reads as zero regardless of what the register file returns.
  assign w_op1 = (w_instr.rb == R0) ? {DATA_W{1'b0}} :
                 (w_byp_b ? bus.wb_data : bus.rf_data1);
  assign w_op2 = (w_src2 == R0) ? {DATA_W{1'b0}} :
                 (w_byp_s2 ? bus.wb_data : bus.rf_data2);

  // Holding register FSM: capture on accept, drain on out_ready, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_op1       <= {DATA_W{1'b0}};
      r_op2       <= {DATA_W{1'b0}};
      r_dest      <= {AW{1'b0}};
      r_wr        <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state     <= ST_FULL;
            r_out_valid <= 1'b1;
            r_op1       <= w_op1;
            r_op2       <= w_op2;
            r_dest      <= w_instr.ra;
            r_wr        <= w_instr.wr_ra && (w_instr.ra != R0);
          end
        end
        ST_FULL: begin
          if (w_accept) begin
            r_out_valid <= 1'b1;
            r_op1       <= w_op1;
            r_op2       <= w_op2;
            r_dest      <= w_instr.ra;
            r_wr        <= w_instr.wr_ra && (w_instr.ra != R0);
          end else if (bus.out_ready) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_op1   = r_op1;
  assign bus.out_op2   = r_op2;
  assign bus.out_dest  = r_dest;
  assign bus.out_wr    = r_wr;

endmodule
